perf_sampler: RTL

Periodic snapshot engine that sits directly downstream of the NPU performance counter block. It is the sole master of that block's register bus. On a timer tick or a software trigger it freezes the counters, reads the enabled 48-bit counters as LO/HI word pairs, then unfreezes them. Each snapshot is packed into a framed 32-bit word stream, buffered in an internal FIFO, and drained to the trace/DMA path over valid/ready.

---
 rtl/npu_pkg.sv | 57 +++++
 rtl/sync_fifo.sv | 57 +++++
 rtl/perf_sampler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: perf counter register map, slot ids and
// sampler FSM encoding.
package npu_pkg;

    localparam logic [7:0] PC_CTRL      = 8'h00;
    localparam logic [7:0] PC_CYCLE_LO  = 8'h10;
    localparam logic [7:0] PC_PE_ACT_LO = 8'h20;
    localparam logic [7:0] PC_PE_STL_LO = 8'h28;
    localparam logic [7:0] PC_MEM_RD_LO = 8'h30;
    localparam logic [7:0] PC_MEM_WR_LO = 8'h38;
    localparam logic [7:0] PC_DMA_LO    = 8'h40;
    localparam logic [7:0] PC_C_HIT_LO  = 8'h48;
    localparam logic [7:0] PC_C_MISS_LO = 8'h50;
    localparam logic [7:0] PC_INSTR_LO  = 8'h58;
    localparam logic [7:0] PC_HI_OFS    = 8'h04;

    localparam logic [31:0] CTRL_EN     = 32'h1;
    localparam logic [31:0] CTRL_FREEZE = 32'h4;

    localparam logic [7:0] HDR_SYNC = 8'hA5;

    typedef enum logic [3:0] {
        SLOT_CYCLE,
        SLOT_PE_ACTIVE,
        SLOT_PE_STALL,
        SLOT_MEM_READ,
        SLOT_MEM_WRITE,
        SLOT_DMA,
        SLOT_CACHE_HIT,
        SLOT_CACHE_MISS,
        SLOT_INSTR
    } slot_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FREEZE = 3'd1;
    localparam state_t ST_HDR    = 3'd2;
    localparam state_t ST_READ   = 3'd3;
    localparam state_t ST_THAW   = 3'd4;

    function automatic logic [7:0] slot_lo(input slot_e s);
        case (s)
            SLOT_CYCLE:      slot_lo = PC_CYCLE_LO;
            SLOT_PE_ACTIVE:  slot_lo = PC_PE_ACT_LO;
            SLOT_PE_STALL:   slot_lo = PC_PE_STL_LO;
            SLOT_MEM_READ:   slot_lo = PC_MEM_RD_LO;
            SLOT_MEM_WRITE:  slot_lo = PC_MEM_WR_LO;
            SLOT_DMA:        slot_lo = PC_DMA_LO;
            SLOT_CACHE_HIT:  slot_lo = PC_C_HIT_LO;
            SLOT_CACHE_MISS: slot_lo = PC_C_MISS_LO;
            SLOT_INSTR:      slot_lo = PC_INSTR_LO;
            default:         slot_lo = PC_CYCLE_LO;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           valid,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        inc = (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid   = (level != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && (level != LW'(DEPTH));
    // Output is gated so stale storage never leaks out while empty.
    assign rdata   = valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= inc(wptr);
            if (do_pop)  rptr <= inc(rptr);
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/perf_sampler.sv
// Periodic perf counter snapshot engine: freezes the counter block,
// reads enabled 48-bit counters and streams framed words out.
module perf_sampler
    import npu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_SLOTS    = 9,
    parameter int FIFO_DEPTH   = 32,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_en,
    input  logic [PERIOD_WIDTH-1:0]           cfg_period,
    input  logic [NUM_SLOTS-1:0]              cfg_mask,
    input  logic                              sw_trigger,
    output logic                              pc_reg_wr,
    output logic [ADDR_WIDTH-1:0]             pc_reg_addr,
    output logic [DATA_WIDTH-1:0]             pc_reg_wdata,
    input  logic [DATA_WIDTH-1:0]             pc_reg_rdata,
    output logic                              smp_valid,
    input  logic                              smp_ready,
    output logic [DATA_WIDTH-1:0]             smp_data,
    output logic                              smp_last,
    output logic                              busy,
    output logic [15:0]                       drop_cnt,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(NUM_SLOTS);

    state_t                  state;
    logic [PERIOD_WIDTH-1:0] timer;
    logic                    en_q;
    logic                    pending;
    logic                    hi;
    logic [7:0]              seq;
    logic [NUM_SLOTS-1:0]    mask_q;
    logic [NUM_SLOTS-1:0]    rem;
    logic [NUM_SLOTS-1:0]    rem_next;
    logic [SW-1:0]           slot;
    logic [ADDR_WIDTH-1:0]   lo_addr;
    logic                    tick;
    logic                    trig;
    logic                    fits;
    logic                    accept;
    logic                    set_pend;
    logic [1:0]              n_drop;
    logic [LW:0]             need;
    logic [LW:0]             room;
    logic [16:0]             dsum;
    logic                    push;
    logic [DATA_WIDTH:0]     push_data;
    logic [DATA_WIDTH:0]     fifo_q;

    assign tick = cfg_en && en_q && (cfg_period != '0)
                  && (timer == PERIOD_WIDTH'(1));
    assign trig = tick || sw_trigger;
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer <= '0;
            en_q  <= 1'b0;
        end else begin
            en_q <= cfg_en;
            if (!cfg_en || cfg_period == '0) begin
                timer <= '0;
            end else if (!en_q || timer <= PERIOD_WIDTH'(1)) begin
                timer <= cfg_period;
            end else begin
                timer <= timer - 1'b1;
            end
        end
    end

    always_comb begin
        need = (LW+1)'(1);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            need = need + (LW+1)'({cfg_mask[i], 1'b0});
        end
        room = (LW+1)'(FIFO_DEPTH) - {1'b0, fifo_level};
        fits = (need <= room);
    end

    // A fresh trigger landing on an already-pending one in IDLE is dropped.
    always_comb begin
        n_drop   = 2'd0;
        set_pend = 1'b0;
        if (state == ST_IDLE) begin
            if (pending && trig) n_drop = n_drop + 2'd1;
            if ((pending || trig) && !fits) n_drop = n_drop + 2'd1;
        end else if (trig) begin
            if (pending) n_drop = 2'd1;
            else set_pend = 1'b1;
        end
    end

    assign accept = (state == ST_IDLE) && (pending || trig) && fits;
    assign dsum   = {1'b0, drop_cnt} + 17'(n_drop);

    always_comb begin
        slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (rem[i]) slot = SW'(i);
        end
        rem_next       = rem;
        rem_next[slot] = 1'b0;
    end

    assign lo_addr = ADDR_WIDTH'(slot_lo(slot_e'(slot)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mask_q   <= '0;
            rem      <= '0;
            hi       <= 1'b0;
            pending  <= 1'b0;
            seq      <= '0;
            drop_cnt <= '0;
        end else begin
            seq <= seq + 8'(n_drop) + 8'(state == ST_THAW);
            drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
            if (state == ST_IDLE) pending <= 1'b0;
            else if (set_pend) pending <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_FREEZE;
                        mask_q <= cfg_mask;
                        rem    <= cfg_mask;
                        hi     <= 1'b0;
                    end
                end
                ST_FREEZE: state <= ST_HDR;
                ST_HDR:    state <= (mask_q == '0) ? ST_THAW : ST_READ;
                ST_READ: begin
                    hi <= !hi;
                    if (hi) begin
                        rem <= rem_next;
                        if (rem_next == '0) state <= ST_THAW;
                    end
                end
                ST_THAW:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_reg_wr    = 1'b0;
        pc_reg_addr  = '0;
        pc_reg_wdata = '0;
        push         = 1'b0;
        push_data    = '0;
        unique case (state)
            ST_FREEZE: begin
                pc_reg_wr    = 1'b1;
                pc_reg_addr  = ADDR_WIDTH'(PC_CTRL);
                pc_reg_wdata = DATA_WIDTH'(CTRL_EN | CTRL_FREEZE);
            end
            ST_HDR: begin
                push      = 1'b1;
                push_data = {mask_q == '0, HDR_SYNC, seq, 16'(mask_q)};
            end
            ST_READ: begin
                push        = 1'b1;
                pc_reg_addr = hi ? lo_addr + ADDR_WIDTH'(PC_HI_OFS) : lo_addr;
                push_data   = {hi && (rem_next == '0), pc_reg_rdata};
            end
            ST_THAW: begin
                pc_reg_wr    = 1'b1;
                pc_reg_addr  = ADDR_WIDTH'(PC_CTRL);
                pc_reg_wdata = DATA_WIDTH'(CTRL_EN);
            end
            default: ;
        endcase
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_data),
        .pop   (smp_valid && smp_ready),
        .rdata (fifo_q),
        .valid (smp_valid),
        .level (fifo_level)
    );

    assign smp_data = fifo_q[DATA_WIDTH-1:0];
    assign smp_last = fifo_q[DATA_WIDTH];

endmodule
